// File: rtl/priority_decoder2to4_pulse_pkg.sv
// Shared definitions for the 2-to-4 pulse decoder: FSM states, index constants
// (kept identical to the priority encoder's mapping) and the index-to-one-hot helper.
package priority_decoder2to4_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  localparam logic [1:0] IDX_D0 = 2'd0;
  localparam logic [1:0] IDX_D1 = 2'd1;
  localparam logic [1:0] IDX_D2 = 2'd2;
  localparam logic [1:0] IDX_D3 = 2'd3;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = '0;
    unique case (idx)
      IDX_D0: oh[IDX_D0] = 1'b1;
      IDX_D1: oh[IDX_D1] = 1'b1;
      IDX_D2: oh[IDX_D2] = 1'b1;
      IDX_D3: oh[IDX_D3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/priority_decoder2to4_pulse_hold_counter.sv
// Loadable down-counter with zero flag; times how long the selected D line stays high.
module hold_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_value,
  output logic             o_is_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_value   = r_count;
  assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/priority_decoder2to4_pulse.sv
// Re-expands an accepted 2-bit index into a timed one-hot pulse on D3..D0,
// terminated by hold expiry or early ack, always followed by a one-cycle gap.
module priority_decoder2to4_pulse #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A1,
  input  logic       A0,
  input  logic       V,
  input  logic       ack,
  output logic       in_ready,
  output logic       D0,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       busy,
  output logic       done,
  output logic [1:0] code_q
);

  import priority_decoder2to4_pulse_pkg::*;

  // A hold of 0 behaves as a hold of 1.
  localparam int unsigned    HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_EFF - 1);

  if (((HOLD_EFF - 1) >> CNT_W) != 0) begin : g_hold_range_check
    $error("HOLD_CYCLES-1 does not fit in CNT_W bits");
  end

  state_e           r_state;
  logic [3:0]       r_d;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_code;

  logic [1:0]       w_idx;
  logic             w_accept;
  logic             w_term;
  logic             w_dec;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_value;

  assign w_idx    = {A1, A0};
  assign w_accept = (r_state == ST_IDLE) && V;
  // ack and expiry together still yield a single termination.
  assign w_term   = (r_state == ST_ACTIVE) && (ack || w_cnt_zero);
  assign w_dec    = (r_state == ST_ACTIVE) && !w_term && (w_cnt_value != '0);

  hold_counter #(
    .CNT_W(CNT_W)
  ) u_hold_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_load_val(LOAD_VAL),
    .i_dec     (w_dec),
    .o_value   (w_cnt_value),
    .o_is_zero (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_code  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code  <= w_idx;
            r_d     <= idx_to_onehot(w_idx);
            r_busy  <= 1'b1;
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_term) begin
            r_d     <= '0;
            r_done  <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_d     <= '0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign D0       = r_d[IDX_D0];
  assign D1       = r_d[IDX_D1];
  assign D2       = r_d[IDX_D2];
  assign D3       = r_d[IDX_D3];
  assign busy     = r_busy;
  assign done     = r_done;
  assign code_q   = r_code;

endmodule

// File: tb/tb_priority_decoder2to4_pulse.sv
// Scoreboard bench: two decoder instances (hold 4 and hold 1) driven by directed
// vectors; every cycle with a D line or done high is popped against the expected queue.
module tb_priority_decoder2to4_pulse;

  typedef struct packed {
    logic [3:0] d;
    logic       done;
    logic [1:0] code;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v4, ack4, v1, ack1;
  logic [1:0] a4, a1;
  logic       in_ready4, busy4, done4, in_ready1, busy1, done1;
  logic [3:0] d4, d1;
  logic [1:0] code4, code1;

  obs_t exp4[$];
  obs_t exp1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  priority_decoder2to4_pulse #(.HOLD_CYCLES(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .A1(a4[1]), .A0(a4[0]), .V(v4), .ack(ack4),
    .in_ready(in_ready4), .D0(d4[0]), .D1(d4[1]), .D2(d4[2]), .D3(d4[3]),
    .busy(busy4), .done(done4), .code_q(code4)
  );

  priority_decoder2to4_pulse #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .A1(a1[1]), .A0(a1[0]), .V(v1), .ack(ack1),
    .in_ready(in_ready1), .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
    .busy(busy1), .done(done1), .code_q(code1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int id, input int count, input logic [3:0] d,
                      input logic dn, input logic [1:0] c);
    obs_t o;
    o = '{d: d, done: dn, code: c};
    for (int i = 0; i < count; i++) begin
      if (id == 0) exp4.push_back(o);
      else         exp1.push_back(o);
    end
  endtask

  task automatic mon(input int id, input logic [3:0] d, input logic dn,
                     input logic [1:0] c, input logic bz);
    obs_t  o, e;
    string tag;
    int    qsize;
    tag   = (id == 0) ? "dut4" : "dut1";
    o     = '{d: d, done: dn, code: c};
    qsize = (id == 0) ? exp4.size() : exp1.size();
    check({tag, "_onehot_invariant"}, 16'($countones(d) <= 1), 16'd1);
    check({tag, "_d_low_when_not_busy"}, 16'(bz || (d == 4'd0)), 16'd1);
    if (d != 4'd0 || dn) begin
      if (qsize == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected_output: actual=%0h required=none", tag, o);
      end else begin
        if (id == 0) e = exp4.pop_front();
        else         e = exp1.pop_front();
        check({tag, "_scoreboard"}, 16'(o), 16'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, d4, done4, code4, busy4);
    mon(1, d1, done1, code1, busy1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_st(input int id, input string name, input logic rdy, input logic bz,
                          input logic dn, input logic [3:0] d, input logic [1:0] c);
    logic [15:0] act;
    if (id == 0) act = {7'd0, in_ready4, busy4, done4, d4, code4};
    else         act = {7'd0, in_ready1, busy1, done1, d1, code1};
    check(name, act, {7'd0, rdy, bz, dn, d, c});
  endtask

  task automatic wait_ready(input int id, input int maxc, output int cyc);
    logic rdy;
    cyc = 0;
    rdy = (id == 0) ? in_ready4 : in_ready1;
    while (rdy !== 1'b1 && cyc < maxc) begin
      step();
      cyc++;
      rdy = (id == 0) ? in_ready4 : in_ready1;
    end
    if (rdy !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready_timeout: actual=%0d cycles required=ready", cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    v4 = 1'b0; ack4 = 1'b0; a4 = 2'b00;
    v1 = 1'b0; ack1 = 1'b0; a1 = 2'b00;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      step();
      check_st(0, "reset_hold", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_st(0, "idle_after_reset", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00);
      check_st(1, "idle_after_reset_h1", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00);
    end

    // Full pulse on index 2, with V for index 1 held while busy
    v4 = 1'b1; a4 = 2'b10;
    push(0, 4, 4'b0100, 1'b0, 2'b10);
    push(0, 1, 4'b0000, 1'b1, 2'b10);
    step();
    a4 = 2'b01;
    push(0, 4, 4'b0010, 1'b0, 2'b01);
    push(0, 1, 4'b0000, 1'b1, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      check_st(0, "full_pulse_busy", 1'b0, 1'b1, (i == 5), (i < 5) ? 4'b0100 : 4'b0000, 2'b10);
      step();
    end
    check_st(0, "full_pulse_ready", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b10);
    step();
    v4 = 1'b0;
    check_st(0, "held_v_accepted", 1'b0, 1'b1, 1'b0, 4'b0010, 2'b01);
    wait_ready(0, 20, c);

    // Early ack on 2nd active cycle of index 3
    v4 = 1'b1; a4 = 2'b11;
    push(0, 2, 4'b1000, 1'b0, 2'b11);
    push(0, 1, 4'b0000, 1'b1, 2'b11);
    step();
    v4 = 1'b0;
    step();
    ack4 = 1'b1;
    step();
    ack4 = 1'b0;
    check_st(0, "early_ack_gap", 1'b0, 1'b1, 1'b1, 4'b0000, 2'b11);
    step();
    check_st(0, "early_ack_idle", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b11);

    // ack held from accept: 1-cycle pulse, ack in GAP/IDLE ignored
    v4 = 1'b1; a4 = 2'b01; ack4 = 1'b1;
    push(0, 1, 4'b0010, 1'b0, 2'b01);
    push(0, 1, 4'b0000, 1'b1, 2'b01);
    step();
    v4 = 1'b0;
    step();
    step();
    check_st(0, "ack_first_cycle_idle", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01);
    step();
    check_st(0, "ack_in_idle_ignored", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01);
    ack4 = 1'b0;

    // Reset in 3rd active cycle of index 0
    v4 = 1'b1; a4 = 2'b00;
    push(0, 3, 4'b0001, 1'b0, 2'b00);
    step();
    v4 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_st(0, "reset_mid_pulse", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00);
    rst_n = 1'b1;
    step();
    check_st(0, "reset_mid_no_done", 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00);

    // HOLD_CYCLES=1: all indices back-to-back at minimum spacing
    wait_ready(1, 10, c);
    for (int idx = 0; idx < 4; idx++) begin
      v1 = 1'b1; a1 = 2'(idx);
      push(1, 1, 4'b0001 << idx, 1'b0, 2'(idx));
      push(1, 1, 4'b0000, 1'b1, 2'(idx));
      step();
      v1 = 1'b0;
      check_st(1, "h1_active", 1'b0, 1'b1, 1'b0, 4'b0001 << idx, 2'(idx));
      wait_ready(1, 10, c);
      check("h1_accept_spacing", 16'(c + 1), 16'd3);
    end

    repeat (3) step();
    check("dut4_queue_drained", 16'(exp4.size()), 16'd0);
    check("dut1_queue_drained", 16'(exp1.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
